// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-slot pipeline register with stall, flush and sticky halt squash.
// Define PIPE_STAGE_STATS_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_halt,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_halt,
  output logic              halted,
`ifdef PIPE_STAGE_STATS_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic              drained
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be 1..4");
  end
  typedef enum logic {RUN, HALT_ST} state_t;
  state_t state;
  logic [DEPTH-1:0] v, h;
  logic [DATA_W-1:0] d [DEPTH];
  logic [CTRL_W-1:0] c [DEPTH];
  logic v0, h0;
  logic [DATA_W-1:0] d0;
  logic [CTRL_W-1:0] c0;
  // Once halted, slot 0 only ever sees halt-marked bubbles
  assign v0 = (state == RUN) & in_valid;
  assign h0 = (state == RUN) ? in_valid & in_halt : 1'b1;
  assign d0 = v0 ? in_data : '0;
  assign c0 = v0 ? in_ctrl : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      v <= '0;
      h <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else if (flush) begin
      state <= RUN;
      v <= '0;
      h <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else if (!stall) begin
      state <= (state == RUN && in_valid && in_halt) ? HALT_ST : state;
      for (int i = DEPTH - 1; i > 0; i--) begin
        v[i] <= v[i-1];
        h[i] <= h[i-1];
        d[i] <= d[i-1];
        c[i] <= c[i-1];
      end
      v[0] <= v0;
      h[0] <= h0;
      d[0] <= d0;
      c[0] <= c0;
    end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_ctrl  = v[DEPTH-1] ? c[DEPTH-1] : '0;
  assign out_halt  = h[DEPTH-1];
  assign halted    = state == HALT_ST;
  assign drained   = halted & out_halt;
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!flush) begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (!stall && !v0 && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg at DEPTH 1, 2 and 3.
module tb_pipe_stage_reg;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_halt = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [47:0] in_data = '0;
  logic [7:0] in_ctrl = '0;
  logic ov [1:3], oh [1:3], hl [1:3], dr [1:3];
  logic [47:0] od [1:3];
  logic [7:0] oc [1:3];
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] sc [1:3], bc [1:3];
`endif
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 1; g <= 3; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(48), .CTRL_W(8), .DEPTH(g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
      .in_halt(in_halt), .stall(stall), .flush(flush), .out_valid(ov[g]), .out_data(od[g]),
      .out_ctrl(oc[g]), .out_halt(oh[g]), .halted(hl[g]),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cnt(sc[g]), .bubble_cnt(bc[g]),
`endif
      .drained(dr[g]));
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {in_valid, in_halt, stall, flush} = '0;
    in_data = '0;
    in_ctrl = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask
  initial begin
    // 1: reset and DEPTH=2 pass-through
    #1;
    chk("rst_valid", ov[2], 0);
    chk("rst_data", od[2], 0);
    chk("rst_halted", hl[3], 0);
    in_valid = 1; in_data = 48'h1234; in_ctrl = 8'hA5;
    tick();
    chk("rst_hold_valid", ov[2], 0);
    chk("rst_hold_ctrl", oc[2], 0);
    rst = 1;
    tick();
    in_valid = 0;
    chk("p2_edge1_valid", ov[2], 0);
    tick();
    chk("p2_edge2_valid", ov[2], 1);
    chk("p2_edge2_data", od[2], 48'h1234);
    chk("p2_edge2_ctrl", oc[2], 8'hA5);
    tick();
    chk("p2_bubble_valid", ov[2], 0);
    chk("p2_bubble_ctrl", oc[2], 0);
    chk("p2_bubble_data", od[2], 0);
    // 2: DEPTH=1 stall hold
    do_reset();
    in_valid = 1; in_data = 48'h5555;
    tick();
    chk("st_cap", od[1], 48'h5555);
    stall = 1; in_data = 48'hAAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold", od[1], 48'h5555);
    end
    stall = 0;
    tick();
    chk("st_release", od[1], 48'hAAAA);
    // 3: DEPTH=3 flush beats stall
    do_reset();
    in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      in_ctrl = 8'(i * 17); in_data = 48'(i);
      tick();
    end
    chk("fl_full_valid", ov[3], 1);
    chk("fl_full_ctrl", oc[3], 8'h11);
    flush = 1; stall = 1;
    tick();
    chk("fl_valid", ov[3], 0);
    chk("fl_ctrl", oc[3], 0);
    chk("fl_halted", hl[3], 0);
    flush = 0; stall = 0; in_data = 48'h77; in_ctrl = 8'h44;
    tick();
    in_valid = 0;
    tick();
    chk("fl_lat2", ov[3], 0);
    tick();
    chk("fl_lat3_valid", ov[3], 1);
    chk("fl_lat3_data", od[3], 48'h77);
    chk("fl_lat3_ctrl", oc[3], 8'h44);
    // 4: DEPTH=2 halt squash
    do_reset();
    in_valid = 1; in_halt = 1; in_data = 48'h99; in_ctrl = 8'h0F;
    tick();
    chk("h_halted", hl[2], 1);
    chk("h_drained0", dr[2], 0);
    in_halt = 0; in_ctrl = 8'hFF; in_data = 48'hBEEF;
    tick();
    chk("h_out_valid", ov[2], 1);
    chk("h_out_halt", oh[2], 1);
    chk("h_out_ctrl", oc[2], 8'h0F);
    chk("h_drained", dr[2], 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hs_valid", ov[2], 0);
      chk("hs_ctrl", oc[2], 0);
      chk("hs_halt", oh[2], 1);
      chk("hs_drained", dr[2], 1);
    end
    // 5: flush while halted, then flush on the halt capture edge
    flush = 1; in_valid = 0;
    tick();
    chk("hf_halted", hl[2], 0);
    chk("hf_drained", dr[2], 0);
    chk("hf_halt", oh[2], 0);
    chk("hf_valid", ov[2], 0);
    flush = 0;
    tick();
    chk("hf_run_halt", oh[2], 0);
    in_valid = 1; in_halt = 1; flush = 1;
    tick();
    chk("hfs_halted", hl[2], 0);
    flush = 0; in_valid = 0; in_halt = 0;
    tick();
    tick();
    chk("hfs_halt", oh[2], 0);
    chk("hfs_valid", ov[2], 0);
    chk("hfs_halted2", hl[2], 0);
    // reset while halted clears immediately
    in_valid = 1; in_halt = 1;
    tick();
    chk("hr_pre", hl[1], 1);
    chk("hr_pre_drained", dr[1], 1);
    rst = 0;
    #1;
    chk("hr_halted", hl[1], 0);
    chk("hr_out_halt", oh[1], 0);
    chk("hr_valid", ov[1], 0);
    rst = 1; in_valid = 0; in_halt = 0;
`ifdef PIPE_STAGE_STATS_EN
    // 6: statistics counters
    do_reset();
    stall = 1;
    repeat (5) tick();
    chk("stat_stall5", sc[1], 5);
    chk("stat_bub0", bc[1], 0);
    stall = 0;
    repeat (3) tick();
    chk("stat_bub3", bc[1], 3);
    chk("stat_stall_keep", sc[1], 5);
    flush = 1;
    tick();
    flush = 0;
    chk("stat_flush_bub", bc[1], 3);
    stall = 1;
    repeat (65540) tick();
    chk("stat_sat", sc[1], 16'hFFFF);
    stall = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
